uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (range 2..8).
REQ-002 SHALL have parameter BURST_MAX, default 16, max consecutive bytes per grant while locked (range 1..255).
REQ-003 SHALL have parameter SYNC_RESET, default 1, fixed at 1; reset is synchronous and active-high.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous active-high reset.
REQ-006 EN  input  1  arbitration enable; 0 blocks new grants but lets the byte in flight finish.
REQ-007 REQ  input  NUM_REQ  per-requester byte-pending request, held until that requester's ACK.
REQ-008 LOCK  input  NUM_REQ  per-requester burst lock; keeps ownership while REQ stays high.
REQ-009 DATA  input  8*NUM_REQ  per-requester byte; bits [8i+7:8i] belong to requester i.
REQ-010 ACK  output  NUM_REQ  one-cycle pulse on requester i when its byte is loaded.
REQ-011 TX_RDY  input  1  transmitter idle/ready flag, active high.
REQ-012 TX_DATA  output  8  byte to transmitter, valid while TX_LOAD=1.
REQ-013 TX_LOAD  output  1  one-cycle load strobe to transmitter.
REQ-014 BUSY  output  1  high in every state except IDLE.
REQ-015 OWNER  output  clog2(NUM_REQ)  index of current or last owner.

Function
REQ-016 States SHALL be IDLE, LOAD, SETTLE and WAIT.
REQ-017 IDLE->LOAD SHALL occur when EN=1, TX_RDY=1 and any REQ bit is high; winner latched into OWNER.
REQ-018 Winner SHALL be first requester with REQ=1 searching upward from pointer PTR, wrapping NUM_REQ-1 -> 0.
REQ-019 LOAD SHALL last exactly one cycle: TX_LOAD=1, TX_DATA=DATA[OWNER], ACK[OWNER]=1; burst count BCNT increments.
REQ-020 LOAD->SETTLE unconditionally; SETTLE SHALL last one cycle, ignoring TX_RDY, to allow the transmitter to drop TX_RDY.
REQ-021 SETTLE->WAIT unconditionally; WAIT SHALL hold until TX_RDY=1.
REQ-022 On TX_RDY=1 in WAIT: if EN=1, REQ[OWNER]=1, LOCK[OWNER]=1 and BCNT<BURST_MAX, SHALL go directly to LOAD with same OWNER.
REQ-023 Otherwise on TX_RDY=1 in WAIT: SHALL go to IDLE, set PTR=(OWNER+1) mod NUM_REQ, clear BCNT.
REQ-024 Latency REQ rise (in IDLE, TX_RDY=1, EN=1) to TX_LOAD SHALL be 1 cycle; idle-to-idle minimum byte cycle SHALL be 4 clocks plus transmitter time.
REQ-025 Deassertion of REQ[OWNER] after ACK SHALL not be required to terminate a burst beyond REQ-022 check.
REQ-026 REQ or LOCK changes during SETTLE/WAIT SHALL only be sampled at WAIT exit.
REQ-027 EN falling mid-byte SHALL not abort; block returns to IDLE at WAIT exit and stays there.
REQ-028 Only one ACK bit and at most one TX_LOAD SHALL be high in any cycle; ACK and TX_LOAD coincident.
REQ-029 BCNT SHALL be 8 bits, saturate at BURST_MAX, never wrap.
REQ-030 With no REQ bits high, IDLE SHALL hold and PTR SHALL not change.

Reset
REQ-031 RESET=1 at a rising edge SHALL force IDLE, PTR=0, BCNT=0, OWNER=0, ACK=0, TX_LOAD=0, TX_DATA=0, BUSY=0.
REQ-032 Reset mid-burst SHALL drop ownership immediately; no ACK or TX_LOAD in the cycle after reset.

Structure
REQ-033 State enumeration, default NUM_REQ/BURST_MAX and owner-width function SHALL live in shared package uart_pkg.
REQ-034 Round-robin search SHALL be sub-module uart_rr_picker (combinational: REQ, PTR -> valid, index).
REQ-035 TX_DATA, TX_LOAD, ACK SHALL be registered outputs.

Verification
REQ-036 Single request: REQ=0b0010, DATA[1]=0xA5, TX_RDY=1 -> TX_LOAD with TX_DATA=0xA5 and ACK=0b0010 one cycle later; OWNER=1.
REQ-037 Round-robin: REQ=0b1111 held, LOCK=0, transmitter model 10-cycle busy -> ACK order 0,1,2,3,0.
REQ-038 Burst: BURST_MAX=3, REQ=0b0011, LOCK[0]=1 -> 3 loads for requester 0, then requester 1.
REQ-039 Wrap: PTR=3, REQ=0b1001 -> requester 3 granted, then requester 0.
REQ-040 EN drop during WAIT with REQ=0b0001 -> current byte completes, no further TX_LOAD until EN=1.
REQ-041 RESET asserted in SETTLE -> next cycle BUSY=0, PTR=0, no ACK; re-grant after RESET release.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   arb_state_t   - arbiter FSM state encoding
//   DEF_NUM_REQ   - default number of requesters
//   DEF_BURST_MAX - default burst length limit while locked
//   owner_w()     - width of the owner / pointer index for n requesters
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_WAIT   = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_MAX = 16;

    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Requester / transmitter side bundle of the UART transmit arbiter.
//   en       arbitration enable
//   req      per-requester byte pending
//   lock     per-requester burst lock
//   data     per-requester byte, [8i+7:8i] belongs to requester i
//   ack      one-cycle pulse to the requester whose byte was loaded
//   tx_rdy   transmitter ready
//   tx_data  byte to transmitter, valid with tx_load
//   tx_load  one-cycle load strobe
//   busy     arbiter not idle
//   owner    current or last owner index
// Modports: master = requesters + transmitter, slave = arbiter.
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) ();

    localparam int OW = owner_w(NUM_REQ);

    logic                   en;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     lock;
    logic [8*NUM_REQ-1:0]   data;
    logic [NUM_REQ-1:0]     ack;
    logic                   tx_rdy;
    logic [7:0]             tx_data;
    logic                   tx_load;
    logic                   busy;
    logic [OW-1:0]          owner;

    modport master (
        output en, req, lock, data, tx_rdy,
        input  ack, tx_data, tx_load, busy, owner
    );

    modport slave (
        input  en, req, lock, data, tx_rdy,
        output ack, tx_data, tx_load, busy, owner
    );

endinterface

// File: rtl/uart_rr_picker.sv
// ----------------------------------------------------------------------------
// uart_rr_picker
// Combinational round-robin search: first set bit of i_req at or above
// i_ptr, wrapping from NUM_REQ-1 back to 0.
//   i_req    request vector
//   i_ptr    search start index
//   o_valid  any request found
//   o_idx    index of the winner (0 when none)
// ----------------------------------------------------------------------------
module uart_rr_picker
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int OW     = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [OW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [OW-1:0]      o_idx
);

    // Scan from the farthest offset down to zero so the nearest hit wins.
    always_comb begin
        int c;
        c       = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            c = int'(i_ptr) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            if (i_req[c[OW-1:0]]) begin
                o_valid = 1'b1;
                o_idx   = c[OW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte
// sources, with optional burst lock (up to BURST_MAX bytes per grant).
//   i_clk  clock, all state on rising edge
//   i_rst  synchronous active-high reset
//   bus    uart_tx_arbiter_if.slave (requests, data, acks, tx handshake)
//
// state  | meaning
// IDLE   | no owner; grant when en, tx_rdy and any request
// LOAD   | one cycle: tx_load, tx_data and ack[owner] high
// SETTLE | one cycle, tx_rdy ignored so the transmitter can drop it
// WAIT   | hold until tx_rdy; then continue burst or release to IDLE
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int SYNC_RESET = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_tx_arbiter_if.slave   bus
);

    localparam int         OW   = owner_w(NUM_REQ);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);

    if (SYNC_RESET != 1 || NUM_REQ < 2 || NUM_REQ > 8 ||
        BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter set");
    end

    arb_state_t         r_state, w_next_state;
    logic [OW-1:0]      r_owner, w_next_owner;
    logic [OW-1:0]      r_ptr;
    logic [7:0]         r_bcnt;
    logic [7:0]         r_tx_data;
    logic               r_tx_load;
    logic [NUM_REQ-1:0] r_ack;
    logic               w_pick_valid;
    logic [OW-1:0]      w_pick_idx;
    logic               w_burst_ok;
    logic               w_load;
    logic               w_release;
    logic [7:0]         w_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
        assign w_bytes[i] = bus.data[8*i +: 8];
    end

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_burst_ok   = bus.en && bus.req[r_owner] && bus.lock[r_owner] &&
                       (r_bcnt < BMAX);
        case (r_state)
            ST_IDLE: begin
                if (bus.en && bus.tx_rdy && w_pick_valid) begin
                    w_next_state = ST_LOAD;
                    w_next_owner = w_pick_idx;
                end
            end
            ST_LOAD:   w_next_state = ST_SETTLE;
            ST_SETTLE: w_next_state = ST_WAIT;
            ST_WAIT: begin
                if (bus.tx_rdy) w_next_state = w_burst_ok ? ST_LOAD : ST_IDLE;
            end
            default:   w_next_state = ST_IDLE;
        endcase
    end

    assign w_load    = (w_next_state == ST_LOAD);
    assign w_release = (r_state == ST_WAIT) && (w_next_state == ST_IDLE);

    // Outputs are registered on entry to LOAD so they line up with that state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_bcnt    <= '0;
            r_tx_data <= '0;
            r_tx_load <= 1'b0;
            r_ack     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_owner   <= w_next_owner;
            r_tx_load <= w_load;
            r_ack     <= w_load ? (NUM_REQ'(1) << w_next_owner) : '0;
            if (w_load) begin
                r_tx_data <= w_bytes[w_next_owner];
                if (r_bcnt < BMAX) r_bcnt <= r_bcnt + 8'd1;
            end
            if (w_release) begin
                r_bcnt <= '0;
                r_ptr  <= (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
            end
        end
    end

    assign bus.ack     = r_ack;
    assign bus.tx_data = r_tx_data;
    assign bus.tx_load = r_tx_load;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.owner   = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// byte-level reference model (round-robin pointer, owner, burst count).
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int BM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d [NR];
    int         checks = 0;
    int         errors = 0;

    int m_ptr   = 0;
    int m_owner = 0;
    int m_bcnt  = 0;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

    assign bus.data = {d[3], d[2], d[1], d[0]};

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .BURST_MAX  (BM),
        .SYNC_RESET (1)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] rq, input int ptr);
        for (int k = 0; k < NR; k++) begin
            int c = (ptr + k) % NR;
            if (rq[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_load(input int w, input logic [7:0] db);
        chk("tx_load", bus.tx_load, 1);
        chk("ack", bus.ack, 32'(1) << w);
        chk("tx_data", bus.tx_data, db);
        chk("owner", bus.owner, w);
        chk("busy_load", bus.busy, 1);
    endtask

    task automatic quiet(input string tag, input logic exp_busy);
        chk({tag, "_tx_load"}, bus.tx_load, 0);
        chk({tag, "_ack"}, bus.ack, 0);
        chk({tag, "_busy"}, bus.busy, exp_busy);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        quiet("rst", 0);
        chk("rst_owner", bus.owner, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        rst = 1'b0;
        m_ptr = 0; m_owner = 0; m_bcnt = 0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NR; i++) begin
            if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
                bus.req[i] = 1'b1;
                d[i] = 8'($urandom);
            end
        end
        bus.lock = 4'($urandom);
        bus.en   = ($urandom_range(0, 7) != 0);
    endtask

    // DUT sits in IDLE; one edge either grants or stays idle.
    task automatic grant_idle(output bit granted);
        logic [NR-1:0] s_req;
        bit            s_ok;
        int            w;
        logic [7:0]    s_d;
        s_req = bus.req;
        s_ok  = bus.en && bus.tx_rdy && (s_req != 0);
        w     = rr_pick(s_req, m_ptr);
        s_d   = (w >= 0) ? d[w] : 8'h00;
        tick();
        if (s_ok) begin
            check_load(w, s_d);
            m_owner = w; m_bcnt = 1; granted = 1'b1;
        end else begin
            quiet("idle", 0);
            chk("idle_owner", bus.owner, m_owner);
            granted = 1'b0;
        end
    endtask

    // Called while the load strobe is visible; runs settle/wait and the exit.
    task automatic finish_byte(input int busy_cycles, input bit rnd, output bit rb);
        bit         s_cont;
        logic [7:0] s_d;
        if (rnd) begin
            if ($urandom_range(0, 1) != 0) bus.req[m_owner] = 1'b0;
            d[m_owner] = 8'($urandom);
            rand_inputs();
        end
        bus.tx_rdy = 1'($urandom_range(0, 1));
        tick();
        quiet("settle", 1);
        bus.tx_rdy = 1'($urandom_range(0, 1));
        if (rnd) rand_inputs();
        tick();
        quiet("wait", 1);
        for (int i = 0; i < busy_cycles; i++) begin
            bus.tx_rdy = 1'b0;
            if (rnd) rand_inputs();
            tick();
            quiet("wait_hold", 1);
        end
        bus.tx_rdy = 1'b1;
        if (rnd) rand_inputs();
        s_cont = bus.en && bus.req[m_owner] && bus.lock[m_owner] && (m_bcnt < BM);
        s_d    = d[m_owner];
        tick();
        if (s_cont) begin
            check_load(m_owner, s_d);
            if (m_bcnt < BM) m_bcnt++;
            rb = 1'b1;
        end else begin
            quiet("exit", 0);
            chk("exit_owner", bus.owner, m_owner);
            m_ptr  = (m_owner + 1) % NR;
            m_bcnt = 0;
            rb = 1'b0;
        end
    endtask

    initial begin
        bit g, rb, idle;
        rst = 1'b1;
        bus.en = 1'b0; bus.req = '0; bus.lock = '0; bus.tx_rdy = 1'b0;
        for (int i = 0; i < NR; i++) d[i] = 8'h00;
        tick();
        do_reset();

        // single request
        bus.req = 4'b0010; d[1] = 8'hA5; bus.en = 1'b1; bus.tx_rdy = 1'b1;
        grant_idle(g);
        chk("single_data", bus.tx_data, 8'hA5);
        chk("single_ack", bus.ack, 4'b0010);
        chk("single_owner", bus.owner, 1);
        bus.req = '0;
        finish_byte(2, 1'b0, rb);

        // round robin with all requesters held
        do_reset();
        bus.req = 4'b1111; bus.lock = '0; bus.en = 1'b1; bus.tx_rdy = 1'b1;
        for (int i = 0; i < NR; i++) d[i] = 8'(8'h30 + i);
        for (int k = 0; k < 5; k++) begin
            grant_idle(g);
            chk("rr_owner", bus.owner, k % NR);
            finish_byte(10, 1'b0, rb);
        end

        // burst limited to BM bytes
        do_reset();
        bus.req = 4'b0011; bus.lock = 4'b0001; bus.tx_rdy = 1'b1;
        d[0] = 8'h10; d[1] = 8'h11;
        grant_idle(g);
        chk("burst_g1", bus.owner, 0);
        finish_byte(2, 1'b0, rb);
        chk("burst_load2", bus.tx_load, 1);
        finish_byte(2, 1'b0, rb);
        chk("burst_load3", bus.tx_load, 1);
        finish_byte(2, 1'b0, rb);
        chk("burst_release", bus.busy, 0);
        grant_idle(g);
        chk("burst_next", bus.owner, 1);
        bus.req = '0; bus.lock = '0;
        finish_byte(1, 1'b0, rb);

        // pointer wrap from 3 to 0
        bus.req = 4'b0100; d[2] = 8'h22;
        grant_idle(g);
        bus.req = '0;
        finish_byte(0, 1'b0, rb);
        bus.req = 4'b1001; d[3] = 8'h33; d[0] = 8'h44;
        grant_idle(g);
        chk("wrap_first", bus.owner, 3);
        bus.req[3] = 1'b0;
        finish_byte(1, 1'b0, rb);
        grant_idle(g);
        chk("wrap_second", bus.owner, 0);
        bus.req = '0;
        finish_byte(1, 1'b0, rb);

        // enable drop mid-byte
        bus.req = 4'b0001; bus.lock = 4'b0001; d[0] = 8'h5A;
        grant_idle(g);
        bus.en = 1'b0;
        finish_byte(3, 1'b0, rb);
        chk("en_drop_busy", bus.busy, 0);
        for (int k = 0; k < 3; k++) grant_idle(g);
        bus.en = 1'b1;
        grant_idle(g);
        chk("en_resume", bus.tx_load, 1);
        bus.req = '0; bus.lock = '0;
        finish_byte(1, 1'b0, rb);

        // reset in SETTLE
        bus.req = 4'b0100;
        grant_idle(g);
        bus.req = '0;
        finish_byte(0, 1'b0, rb);
        bus.req = 4'b1000;
        grant_idle(g);
        tick();
        quiet("pre_rst", 1);
        do_reset();
        bus.req = 4'b1010; d[1] = 8'h61; d[3] = 8'h63;
        grant_idle(g);
        chk("rst_regrant", bus.owner, 1);
        bus.req = '0;
        finish_byte(1, 1'b0, rb);

        // randomized traffic
        do_reset();
        bus.req = '0; bus.lock = '0;
        idle = 1'b1;
        for (int it = 0; it < 400; it++) begin
            if (idle) begin
                rand_inputs();
                bus.tx_rdy = ($urandom_range(0, 3) != 0);
                grant_idle(g);
                if (!g) continue;
            end
            finish_byte($urandom_range(0, 3), 1'b1, rb);
            idle = !rb;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
